// File: rtl/sonic_rc_update_ctrl.sv
// rtl/sonic_rc_update_ctrl.sv - RC-update sequencer: trigger collection, one pending request,
// and the START_TX/MWR_REQ/MWR_DV walk of the write engine over the PCIe transmit handshake.
module sonic_rc_update_ctrl #(
   parameter int unsigned START_TX        = 0,
   parameter int unsigned MWR_REQ         = 1,
   parameter int unsigned MWR_DV          = 2,
   parameter int unsigned IDLE            = 3,
   parameter int unsigned BYTE_THRESH     = 1024,
   parameter int unsigned COALESCE_CYCLES = 256,
   parameter int unsigned HOLDOFF_CYCLES  = 16
) (
   input  logic        clk_in,
   input  logic        reset,
   input  logic        init,
   input  logic        enable,
   input  logic        cmd_done,
   input  logic [23:0] byte_ready,
   input  logic        tx_sel,
   input  logic        tx_ready,
   input  logic        tx_ack,
   input  logic        tx_ws,
   input  logic        tx_dv,
   output logic [31:0] cstate,
   output logic [31:0] nstate,
   output logic        pending,
   output logic        irq_sent,
   output logic [31:0] irq_count
);

   typedef enum logic [1:0] {
      ST_START_TX = 2'd0,
      ST_MWR_REQ  = 2'd1,
      ST_MWR_DV   = 2'd2,
      ST_IDLE     = 2'd3
   } state_t;

   localparam logic [15:0] COAL_MAX  = COALESCE_CYCLES[15:0];
   localparam logic [7:0]  HOLD_INIT = HOLDOFF_CYCLES[7:0];

   // Internal encoding is fixed; the externally visible codes follow the parameters.
   function automatic logic [31:0] state_code(input state_t s);
      logic [31:0] code;
      case (s)
         ST_START_TX: code = START_TX;
         ST_MWR_REQ:  code = MWR_REQ;
         ST_MWR_DV:   code = MWR_DV;
         default:     code = IDLE;
      endcase
      return code;
   endfunction

   state_t      state_q, state_d;
   logic        pending_q, pending_d;
   logic        irq_sent_q, irq_sent_d;
   logic [31:0] irq_count_q, irq_count_d;
   logic [15:0] coal_q, coal_d;
   logic [7:0]  hold_q, hold_d;

   logic trigger;
   logic done;

   always_comb begin
      trigger     = cmd_done
                    || ({8'd0, byte_ready} >= BYTE_THRESH)
                    || (coal_q == COAL_MAX);
      done        = (state_q == ST_MWR_DV) && tx_dv && !tx_ws;

      state_d     = state_q;
      pending_d   = trigger || (pending_q && !done);
      irq_sent_d  = done;
      irq_count_d = irq_count_q + {31'd0, done};
      coal_d      = coal_q;
      hold_d      = hold_q;

      case (state_q)
         ST_IDLE: begin
            if (pending_q && enable && (hold_q == 8'd0)) begin
               state_d = ST_START_TX;
            end
         end
         ST_START_TX: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else if (tx_sel && tx_ready) begin
               state_d = ST_MWR_REQ;
            end
         end
         ST_MWR_REQ: begin
            if (tx_ack) begin
               state_d = ST_MWR_DV;
            end
         end
         ST_MWR_DV: begin
            if (done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Timer only runs while no update is owed, so it measures the wait of unserved bytes.
      if ((byte_ready == 24'd0) || irq_sent_q) begin
         coal_d = 16'd0;
      end else if (!pending_q && (coal_q < COAL_MAX)) begin
         coal_d = coal_q + 16'd1;
      end

      if (done) begin
         hold_d = HOLD_INIT;
      end else if ((state_q == ST_IDLE) && (hold_q != 8'd0)) begin
         hold_d = hold_q - 8'd1;
      end

      if (init) begin
         state_d     = ST_IDLE;
         pending_d   = 1'b0;
         irq_sent_d  = 1'b0;
         irq_count_d = 32'd0;
         coal_d      = 16'd0;
         hold_d      = 8'd0;
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         pending_q   <= 1'b0;
         irq_sent_q  <= 1'b0;
         irq_count_q <= 32'd0;
         coal_q      <= 16'd0;
         hold_q      <= 8'd0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         irq_sent_q  <= irq_sent_d;
         irq_count_q <= irq_count_d;
         coal_q      <= coal_d;
         hold_q      <= hold_d;
      end
   end

   assign cstate    = state_code(state_q);
   assign nstate    = state_code(state_d);
   assign pending   = pending_q;
   assign irq_sent  = irq_sent_q;
   assign irq_count = irq_count_q;

endmodule

// File: tb/tb_sonic_rc_update_ctrl.sv
// tb/tb_sonic_rc_update_ctrl.sv - scoreboard bench for sonic_rc_update_ctrl: directed scenarios
// plus randomized traffic against a behavioural reference model.
module tb_sonic_rc_update_ctrl;

   localparam int unsigned P_START = 0;
   localparam int unsigned P_REQ   = 1;
   localparam int unsigned P_DV    = 2;
   localparam int unsigned P_IDLE  = 3;
   localparam int unsigned THRESH  = 1024;
   localparam int unsigned COAL    = 256;
   localparam int unsigned HOLD    = 16;

   logic        clk_in = 1'b0;
   logic        reset  = 1'b1;
   logic        init, enable, cmd_done;
   logic [23:0] byte_ready;
   logic        tx_sel, tx_ready, tx_ack, tx_ws, tx_dv;
   logic [31:0] cstate, nstate, irq_count;
   logic        pending, irq_sent;

   sonic_rc_update_ctrl dut (
      .clk_in     (clk_in),
      .reset      (reset),
      .init       (init),
      .enable     (enable),
      .cmd_done   (cmd_done),
      .byte_ready (byte_ready),
      .tx_sel     (tx_sel),
      .tx_ready   (tx_ready),
      .tx_ack     (tx_ack),
      .tx_ws      (tx_ws),
      .tx_dv      (tx_dv),
      .cstate     (cstate),
      .nstate     (nstate),
      .pending    (pending),
      .irq_sent   (irq_sent),
      .irq_count  (irq_count)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the update owed, the transfer phase, and the two timers as plain values.
   int unsigned m_state   = P_IDLE;
   bit          m_pending = 0;
   bit          m_irq     = 0;
   logic [31:0] m_count   = 32'd0;
   int unsigned m_coal    = 0;
   int unsigned m_hold    = 0;
   int unsigned n_state;
   bit          n_pending, n_irq;
   logic [31:0] n_count;
   int unsigned n_coal, n_hold;
   logic [31:0] exp_q[$];

   task automatic model_next();
      bit owed_new, beat_taken;
      if (reset || init) begin
         n_state = P_IDLE; n_pending = 0; n_irq = 0; n_count = 0; n_coal = 0; n_hold = 0;
         return;
      end
      beat_taken = (m_state == P_DV) && tx_dv && !tx_ws;
      owed_new   = cmd_done || (byte_ready >= THRESH) || (m_coal == COAL);
      n_state = m_state;
      if (m_state == P_IDLE && m_pending && enable && m_hold == 0) n_state = P_START;
      else if (m_state == P_START && !enable) n_state = P_IDLE;
      else if (m_state == P_START && tx_sel && tx_ready) n_state = P_REQ;
      else if (m_state == P_REQ && tx_ack) n_state = P_DV;
      else if (beat_taken) n_state = P_IDLE;
      n_pending = owed_new ? 1'b1 : (beat_taken ? 1'b0 : m_pending);
      n_irq     = beat_taken;
      n_count   = beat_taken ? m_count + 32'd1 : m_count;
      if (byte_ready == 0 || m_irq) n_coal = 0;
      else if (!m_pending && m_coal < COAL) n_coal = m_coal + 1;
      else n_coal = m_coal;
      if (beat_taken) n_hold = HOLD;
      else if (m_state == P_IDLE && m_hold > 0) n_hold = m_hold - 1;
      else n_hold = m_hold;
      if (beat_taken) exp_q.push_back(n_count);
   endtask

   always @(negedge clk_in) begin
      model_next();
      check("cstate", cstate, m_state);
      check("nstate", nstate, n_state);
      check1("pending", pending, m_pending);
      check1("irq_sent", irq_sent, m_irq);
      check("irq_count", irq_count, m_count);
   end

   always @(posedge clk_in or posedge reset) begin
      if (reset) begin
         m_state = P_IDLE; m_pending = 0; m_irq = 0; m_count = 0; m_coal = 0; m_hold = 0;
         exp_q.delete();
      end else begin
         m_state = n_state; m_pending = n_pending; m_irq = n_irq;
         m_count = n_count; m_coal = n_coal; m_hold = n_hold;
      end
   end

   // Completion monitor: every irq_sent pulse must match a completion the model predicted.
   always @(negedge clk_in) begin
      logic [31:0] e;
      if (irq_sent === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected_irq: got irq_sent=1 count=%0d expected no completion", irq_count);
         end else begin
            e = exp_q.pop_front();
            check("sb_irq_count", irq_count, e);
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      init = 0; enable = 1; cmd_done = 0; byte_ready = 0;
      tx_sel = 0; tx_ready = 0; tx_ack = 0; tx_ws = 0; tx_dv = 0;
   endtask

   task automatic quiesce();
      idle_inputs();
      tx_sel = 1; tx_ready = 1; tx_ack = 1; tx_dv = 1;
      repeat (40) tick();
      idle_inputs();
      check("quiesce_idle", cstate, P_IDLE);
   endtask

   task automatic wait_state(input logic [31:0] st, input int limit, output bit found);
      found = 0;
      for (int k = 0; k < limit; k++) begin
         #1;
         if (cstate == st) begin
            found = 1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_irq(input int limit, output bit found);
      found = 0;
      for (int k = 0; k < limit; k++) begin
         tick();
         #1;
         if (irq_sent === 1'b1) begin
            found = 1;
            break;
         end
      end
   endtask

   initial begin
      int          exp_seq[7];
      int          first;
      bit          found;
      logic [31:0] base;
      int          r;

      exp_seq = '{3, 3, 0, 1, 2, 2, 3};
      idle_inputs();
      repeat (3) @(posedge clk_in);
      #1 reset = 0;
      check("rst_cstate", cstate, P_IDLE);
      check("rst_nstate", nstate, P_IDLE);
      check1("rst_pending", pending, 1'b0);
      check("rst_irq_count", irq_count, 32'd0);

      // Command trigger walk-through.
      quiesce();
      base = m_count;
      for (int i = 0; i < 7; i++) begin
         cmd_done = (i == 0); tx_sel = 1; tx_ready = 1;
         tx_ack = (i == 3); tx_dv = (i == 5); tx_ws = 0;
         #1;
         check($sformatf("cmd_seq[%0d]", i), cstate, exp_seq[i]);
         if (i == 6) begin
            check1("cmd_irq_sent", irq_sent, 1'b1);
            check("cmd_irq_count", irq_count, base + 32'd1);
            check1("cmd_pending", pending, 1'b0);
         end
         tick();
      end

      // Coalescing timeout and byte threshold.
      quiesce();
      enable = 0; byte_ready = 24'd10; first = -1;
      for (int k = 0; k < 400; k++) begin
         #1;
         if (pending) begin
            first = k;
            break;
         end
         tick();
      end
      check("coalesce_latency", first, 257);
      quiesce();
      enable = 0; byte_ready = 24'd1024;
      #1 check1("thresh_cycle0", pending, 1'b0);
      tick();
      check1("thresh_cycle1", pending, 1'b1);
      quiesce();

      // Holdoff with a trigger coinciding with completion.
      for (int i = 0; i < 6; i++) begin
         cmd_done = (i == 0 || i == 4); tx_sel = 1; tx_ready = 1;
         tx_ack = 1; tx_dv = (i == 4); tx_ws = 0;
         #1;
         if (i == 4) check("hold_in_dv", cstate, P_DV);
         if (i == 5) begin
            check1("hold_irq", irq_sent, 1'b1);
            check1("hold_pending_kept", pending, 1'b1);
         end
         tick();
      end
      cmd_done = 0; tx_ack = 0; tx_dv = 0; first = -1;
      for (int k = 1; k < 40; k++) begin
         #1;
         if (cstate == P_START) begin
            first = k;
            break;
         end
         tick();
      end
      check("holdoff_latency", first, 17);
      quiesce();

      // Enable dropped in START_TX, then in MWR_REQ.
      base = m_count;
      tx_sel = 0; tx_ready = 1; cmd_done = 1;
      tick();
      cmd_done = 0;
      wait_state(P_START, 10, found);
      check1("en_reach_start", found, 1'b1);
      enable = 0;
      tick();
      check("en_back_idle", cstate, P_IDLE);
      check1("en_pending_kept", pending, 1'b1);
      enable = 1; tx_sel = 1;
      wait_state(P_REQ, 10, found);
      check1("en_reach_req", found, 1'b1);
      enable = 0; tx_ack = 1; tx_dv = 1;
      wait_irq(10, found);
      check1("en_completes", found, 1'b1);
      check("en_irq_count", irq_count, base + 32'd1);
      quiesce();

      // Indefinite wait-state stall, then asynchronous reset mid-transfer.
      tx_sel = 1; tx_ready = 1; tx_ack = 1; tx_dv = 1; tx_ws = 1; cmd_done = 1;
      tick();
      cmd_done = 0;
      wait_state(P_DV, 10, found);
      check1("stall_reach_dv", found, 1'b1);
      repeat (100) tick();
      #1 check("stall_hold", cstate, P_DV);
      reset = 1;
      #1;
      check("arst_cstate", cstate, P_IDLE);
      check("arst_nstate", nstate, P_IDLE);
      check1("arst_pending", pending, 1'b0);
      check1("arst_irq_sent", irq_sent, 1'b0);
      check("arst_irq_count", irq_count, 32'd0);
      tick();
      reset = 0; tx_ws = 0;
      quiesce();

      // Counter wrap from an all-ones preload.
      force dut.irq_count_q = 32'hFFFF_FFFF;
      m_count = 32'hFFFF_FFFF;
      #1 release dut.irq_count_q;
      tx_sel = 1; tx_ready = 1; tx_ack = 1; tx_dv = 1; cmd_done = 1;
      tick();
      cmd_done = 0;
      wait_irq(12, found);
      check1("wrap_irq", found, 1'b1);
      check("wrap_count", irq_count, 32'd0);
      quiesce();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         init     = ($urandom_range(0, 399) == 0);
         enable   = ($urandom_range(0, 7) != 0);
         cmd_done = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 29) == 0) begin
            r = int'($urandom_range(0, 9));
            if (r < 5) byte_ready = 24'd0;
            else if (r < 8) byte_ready = 24'($urandom_range(1, 1023));
            else byte_ready = 24'($urandom_range(1024, 4000));
         end
         tx_sel   = $urandom_range(0, 1) == 1;
         tx_ready = $urandom_range(0, 1) == 1;
         tx_ack   = $urandom_range(0, 2) == 0;
         tx_dv    = $urandom_range(0, 1) == 1;
         tx_ws    = $urandom_range(0, 2) == 0;
         tick();
      end
      quiesce();
      check("sb_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sonic_rc_update_ctrl.md
# sonic_rc_update_ctrl

Sequencer that drives the `cstate`/`nstate` inputs of the RC-update write engine. It collects update triggers (command completion, RX byte threshold, coalescing timeout), holds one pending request, and walks the engine through arbitration, memory-write request and data phases using the PCIe transmit handshake. It sits between the command/datapath status logic and the RC-update engine, one instance per port and mode.

## Interface
Parameters:
- `START_TX`, 0, state code: waiting for the transmit arbiter.
- `MWR_REQ`, 1, state code: memory-write request phase.
- `MWR_DV`, 2, state code: data phase.
- `IDLE`, 3, state code: no transfer in progress.
- `BYTE_THRESH`, 1024, `byte_ready` level that triggers an immediate update.
- `COALESCE_CYCLES`, 256, maximum cycles nonzero `byte_ready` waits before an update; range 1..65535.
- `HOLDOFF_CYCLES`, 16, minimum idle gap after a completed update; range 0..255.

Ports:
- `clk_in`, in, 1, the single clock.
- `reset`, in, 1, asynchronous, active-high reset.
- `init`, in, 1, synchronous clear, same effect as reset.
- `enable`, in, 1, permits new transfers to start.
- `cmd_done`, in, 1, one-cycle pulse: command response is ready.
- `byte_ready`, in, 24, RX bytes awaiting the host.
- `tx_sel`, in, 1, arbiter grant to this requester.
- `tx_ready`, in, 1, engine ready-to-request indication.
- `tx_ack`, in, 1, PCIe core accepted the request.
- `tx_ws`, in, 1, PCIe core wait-state.
- `tx_dv`, in, 1, engine data-valid.
- `cstate`, out, int unsigned, registered current state.
- `nstate`, out, int unsigned, combinational next state.
- `pending`, out, 1, an update is owed.
- `irq_sent`, out, 1, one-cycle pulse when a transfer completes.
- `irq_count`, out, 32, completed transfers.

## Operation
- Trigger sources, evaluated each cycle:
  - `cmd_done==1`.
  - `byte_ready >= BYTE_THRESH`.
  - Coalescing timer reaches `COALESCE_CYCLES`.
- Any trigger sets `pending` on the next edge.
- Coalescing timer:
  - 16-bit.
  - Counts while `byte_ready!=0` and `pending==0`.
  - Saturates at `COALESCE_CYCLES`.
  - Clears when `byte_ready==0` or on `irq_sent`.
- State machine:
  - IDLE → START_TX when `pending && enable && holdoff==0`.
  - START_TX → MWR_REQ when `tx_sel && tx_ready`.
  - START_TX → IDLE when `enable==0`; `pending` is kept.
  - MWR_REQ → MWR_DV when `tx_ack==1`.
  - MWR_DV → IDLE when `tx_dv==1 && tx_ws==0`, i.e. the single 128-bit beat is accepted.
- `enable` is sampled only in IDLE and START_TX. A transfer in MWR_REQ or MWR_DV always completes.
- On the MWR_DV→IDLE edge:
  - `irq_sent` pulses.
  - `irq_count` increments, wrapping at 2^32.
  - `pending` clears.
  - Holdoff counter loads `HOLDOFF_CYCLES`, then decrements to 0 in IDLE.
- Simultaneous trigger and completion in the same cycle: `pending` stays 1. A trigger wins over clear.
- Triggers during a transfer set `pending` immediately. They are served by the next transfer; there is no queueing beyond one.
- `nstate` equals the value `cstate` takes on the next edge. It is a pure function of `cstate`, the inputs and the internal counters.

## Timing
- Reset/init values:
  - `cstate=nstate=IDLE`.
  - `pending=0`, `irq_sent=0`, `irq_count=0`.
  - Coalescing and holdoff counters = 0.
- Reset mid-transfer returns to IDLE in the same cycle (asynchronous). The partial transfer is abandoned; the engine restarts from its own init.
- Trigger-to-START_TX latency, with no holdoff and `enable=1`: trigger at cycle 0 → `pending=1` at cycle 1 → `cstate=START_TX` at cycle 2.
- Each handshake advances `cstate` one cycle after the qualifying input is seen.
- `irq_sent` is asserted in the cycle where `cstate` first reads IDLE after MWR_DV.
- `tx_ws` held high in MWR_DV stalls indefinitely. There is no timeout.

## Test plan
- Command trigger: pulse `cmd_done` at cycle 0; `tx_sel=tx_ready=1`; `tx_ack` at cycle 3; `tx_dv=1,tx_ws=0` at cycle 5.
  - `cstate` sequence 3,3,0,1,2,2,3.
  - `irq_sent` pulses once; `irq_count=1`; `pending=0`.
- Coalescing: `byte_ready=10` held; `COALESCE_CYCLES=256`.
  - `pending` rises exactly 257 cycles after `byte_ready` first becomes nonzero.
  - `byte_ready=1024` instead sets `pending` after 1 cycle.
- Holdoff: two `cmd_done` pulses, the second during MWR_DV; `HOLDOFF_CYCLES=16`.
  - After the first completion, `pending` stays 1.
  - The next START_TX occurs 17 cycles after `irq_sent`.
- Enable: drop `enable` in START_TX.
  - Returns to IDLE with `pending=1`.
  - Dropping it in MWR_REQ still completes the transfer.
- Stall and reset: hold `tx_ws=1` in MWR_DV for 100 cycles; `cstate` stays 2.
  - Assert `reset` mid-stall: all outputs return to reset values asynchronously.
  - `irq_count` is unchanged from its pre-transfer value (0 after reset).
- Counter wrap: preload `irq_count=32'hFFFFFFFF` via forced transfers; one more completion gives 0.
